// File: rtl/int_ctrl_pkg.sv
// Shared types and default sizing for the interrupt controller.
package int_ctrl_pkg;

  localparam int N_SRC_DEF = 8;
  localparam int ID_W_DEF  = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

endpackage

// File: rtl/int_ctrl_prio_enc.sv
// Fixed-priority encoder: the lowest set request index wins.
module prio_enc #(
  parameter int N_SRC = 8,
  parameter int ID_W  = 3
) (
  input  logic [N_SRC-1:0] req,
  output logic [ID_W-1:0]  id,
  output logic             valid
);

  always_comb begin
    id    = '0;
    valid = |req;
    // Scan from the top so that the lowest index is the last one assigned.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        id = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Edge-latched interrupt controller presenting one prioritised request to the core.
//   state      | meaning
//   ST_IDLE    | no request presented; arbitrate pending & enabled sources
//   ST_REQ     | INT high, int_id frozen until ack or until its enable drops
//   ST_SERVICE | core is servicing int_id; wait for eoi (no nesting)
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF,
  parameter int ID_W  = ID_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             en_wr,
  input  logic [N_SRC-1:0] en_din,
  input  logic             int_ack,
  input  logic             eoi,
  output logic             INT,
  output logic [ID_W-1:0]  int_id,
  output logic             in_service,
  output logic [N_SRC-1:0] pending_out
);

  logic [N_SRC-1:0] irq_prev_q, irq_prev_d;
  logic             armed_q, armed_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] en_q, en_d;
  state_e           state_q, state_d;
  logic             int_req_q, int_req_d;
  logic [ID_W-1:0]  int_id_q, int_id_d;
  logic             in_service_q, in_service_d;

  logic [N_SRC-1:0] irq_edge;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] req;
  logic [ID_W-1:0]  win_id;
  logic             win_valid;

  assign req = pending_q & en_q;

  prio_enc #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_prio_enc (
    .req   (req),
    .id    (win_id),
    .valid (win_valid)
  );

  always_comb begin
    irq_prev_d   = irq_in;
    // The first cycle after reset only primes irq_prev, so a line already
    // high at release must be seen low before it can produce an edge.
    armed_d      = 1'b1;
    irq_edge     = armed_q ? (irq_in & ~irq_prev_q) : '0;
    en_d         = en_wr ? en_din : en_q;
    clr          = '0;
    state_d      = state_q;
    int_req_d    = int_req_q;
    int_id_d     = int_id_q;
    in_service_d = in_service_q;

    case (state_q)
      ST_IDLE: begin
        int_req_d    = 1'b0;
        in_service_d = 1'b0;
        if (win_valid) begin
          int_id_d  = win_id;
          int_req_d = 1'b1;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (int_ack) begin
          clr[int_id_q] = 1'b1;
          int_req_d     = 1'b0;
          in_service_d  = 1'b1;
          state_d       = ST_SERVICE;
        end else if (!en_q[int_id_q]) begin
          int_req_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        int_req_d = 1'b0;
        if (eoi) begin
          in_service_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        int_req_d    = 1'b0;
        in_service_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase

    // Set after clear: a new edge on the acked source stays pending.
    pending_d = (pending_q & ~clr) | irq_edge;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_prev_q   <= '0;
      armed_q      <= 1'b0;
      pending_q    <= '0;
      en_q         <= '0;
      state_q      <= ST_IDLE;
      int_req_q    <= 1'b0;
      int_id_q     <= '0;
      in_service_q <= 1'b0;
    end else begin
      irq_prev_q   <= irq_prev_d;
      armed_q      <= armed_d;
      pending_q    <= pending_d;
      en_q         <= en_d;
      state_q      <= state_d;
      int_req_q    <= int_req_d;
      int_id_q     <= int_id_d;
      in_service_q <= in_service_d;
    end
  end

  assign INT         = int_req_q;
  assign int_id      = int_id_q;
  assign in_service  = in_service_q;
  assign pending_out = pending_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed vector bench for int_ctrl: per-cycle stimulus with hand-computed results.
module tb_int_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] irq_in;
  logic       en_wr;
  logic [7:0] en_din;
  logic       int_ack;
  logic       eoi;
  logic       INT;
  logic [2:0] int_id;
  logic       in_service;
  logic [7:0] pending_out;

  int n_checks = 0;
  int n_errors = 0;
  int row      = 0;

  typedef struct {
    logic [7:0] irq;
    logic       wr;
    logic [7:0] din;
    logic       ack;
    logic       eoi;
    logic       x_int;
    logic [2:0] x_id;
    logic       x_svc;
    logic [7:0] x_pend;
  } vec_t;

  vec_t tbl[$];

  int_ctrl #(.N_SRC(8), .ID_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .irq_in      (irq_in),
    .en_wr       (en_wr),
    .en_din      (en_din),
    .int_ack     (int_ack),
    .eoi         (eoi),
    .INT         (INT),
    .int_id      (int_id),
    .in_service  (in_service),
    .pending_out (pending_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic chk_all(input logic e_int, input logic [2:0] e_id, input logic e_svc,
                         input logic [7:0] e_pend);
    chk("INT", {7'd0, INT}, {7'd0, e_int});
    chk("int_id", {5'd0, int_id}, {5'd0, e_id});
    chk("in_service", {7'd0, in_service}, {7'd0, e_svc});
    chk("pending_out", pending_out, e_pend);
  endtask

  task automatic add(input logic [7:0] irq, input logic wr, input logic [7:0] din,
                     input logic ack, input logic e, input logic x_int,
                     input logic [2:0] x_id, input logic x_svc, input logic [7:0] x_pend);
    vec_t v;
    v.irq = irq; v.wr = wr; v.din = din; v.ack = ack; v.eoi = e;
    v.x_int = x_int; v.x_id = x_id; v.x_svc = x_svc; v.x_pend = x_pend;
    tbl.push_back(v);
  endtask

  // Drive one cycle of inputs, clock it, then check the state after that edge.
  task automatic run_vec(input vec_t v);
    irq_in  = v.irq;
    en_wr   = v.wr;
    en_din  = v.din;
    int_ack = v.ack;
    eoi     = v.eoi;
    @(posedge clk);
    #1;
    chk_all(v.x_int, v.x_id, v.x_svc, v.x_pend);
    row++;
  endtask

  initial begin
    vec_t v;

    //   irq    wr  din    ack eoi  INT id svc pend
    // basic single source
    add(8'h00, 1, 8'hFF, 0, 0,   0, 0, 0, 8'h00);
    add(8'h20, 0, 8'h00, 0, 0,   0, 0, 0, 8'h20);
    add(8'h00, 0, 8'h00, 0, 0,   1, 5, 0, 8'h20);
    add(8'h00, 0, 8'h00, 0, 0,   1, 5, 0, 8'h20);
    add(8'h00, 0, 8'h00, 1, 0,   0, 5, 1, 8'h00);
    add(8'h00, 0, 8'h00, 0, 0,   0, 5, 1, 8'h00);
    add(8'h00, 0, 8'h00, 0, 1,   0, 5, 0, 8'h00);
    // two sources in the same cycle: 2 before 6
    add(8'h44, 0, 8'h00, 0, 0,   0, 5, 0, 8'h44);
    add(8'h00, 0, 8'h00, 0, 0,   1, 2, 0, 8'h44);
    add(8'h00, 0, 8'h00, 1, 0,   0, 2, 1, 8'h40);
    add(8'h00, 0, 8'h00, 0, 1,   0, 2, 0, 8'h40);
    add(8'h00, 0, 8'h00, 0, 0,   1, 6, 0, 8'h40);
    add(8'h00, 0, 8'h00, 1, 0,   0, 6, 1, 8'h00);
    add(8'h00, 0, 8'h00, 0, 1,   0, 6, 0, 8'h00);
    // masked source accumulates, then enabled
    add(8'h00, 1, 8'h00, 0, 0,   0, 6, 0, 8'h00);
    add(8'h08, 0, 8'h00, 0, 0,   0, 6, 0, 8'h08);
    add(8'h00, 0, 8'h00, 0, 0,   0, 6, 0, 8'h08);
    add(8'h00, 0, 8'h00, 0, 0,   0, 6, 0, 8'h08);
    add(8'h00, 1, 8'h08, 0, 0,   0, 6, 0, 8'h08);
    add(8'h00, 0, 8'h00, 0, 0,   1, 3, 0, 8'h08);
    add(8'h00, 0, 8'h00, 1, 0,   0, 3, 1, 8'h00);
    add(8'h00, 0, 8'h00, 0, 1,   0, 3, 0, 8'h00);
    // request withdrawn when its enable is cleared
    add(8'h10, 1, 8'h10, 0, 0,   0, 3, 0, 8'h10);
    add(8'h00, 0, 8'h00, 0, 0,   1, 4, 0, 8'h10);
    add(8'h00, 1, 8'h00, 0, 0,   1, 4, 0, 8'h10);
    add(8'h00, 0, 8'h00, 0, 0,   0, 4, 0, 8'h10);
    add(8'h00, 0, 8'h00, 0, 0,   0, 4, 0, 8'h10);
    // ack coinciding with a new edge on the same source
    add(8'h02, 1, 8'hFF, 0, 0,   0, 4, 0, 8'h12);
    add(8'h00, 0, 8'h00, 0, 0,   1, 1, 0, 8'h12);
    add(8'h02, 0, 8'h00, 1, 0,   0, 1, 1, 8'h12);
    add(8'h00, 0, 8'h00, 0, 1,   0, 1, 0, 8'h12);
    add(8'h00, 0, 8'h00, 0, 0,   1, 1, 0, 8'h12);
    add(8'h00, 0, 8'h00, 1, 0,   0, 1, 1, 8'h10);
    add(8'h00, 0, 8'h00, 0, 1,   0, 1, 0, 8'h10);
    add(8'h00, 0, 8'h00, 0, 0,   1, 4, 0, 8'h10);
    add(8'h00, 0, 8'h00, 1, 0,   0, 4, 1, 8'h00);
    add(8'h00, 0, 8'h00, 0, 1,   0, 4, 0, 8'h00);
    // stray ack / eoi in IDLE
    add(8'h00, 0, 8'h00, 1, 0,   0, 4, 0, 8'h00);
    add(8'h00, 0, 8'h00, 0, 1,   0, 4, 0, 8'h00);
    add(8'h00, 0, 8'h00, 1, 1,   0, 4, 0, 8'h00);
    // reach SERVICE with another source pending
    add(8'h01, 0, 8'h00, 0, 0,   0, 4, 0, 8'h01);
    add(8'h00, 0, 8'h00, 0, 0,   1, 0, 0, 8'h01);
    add(8'h00, 0, 8'h00, 1, 0,   0, 0, 1, 8'h00);
    add(8'h80, 0, 8'h00, 0, 0,   0, 0, 1, 8'h80);
    add(8'h00, 0, 8'h00, 0, 0,   0, 0, 1, 8'h80);

    rst     = 1'b0;
    irq_in  = '0;
    en_wr   = 1'b0;
    en_din  = '0;
    int_ack = 1'b0;
    eoi     = 1'b0;
    #12;
    chk_all(0, 0, 0, 8'h00);
    #1 rst = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Asynchronous reset between edges while in SERVICE.
    #2 rst = 1'b0;
    #1;
    chk_all(0, 0, 0, 8'h00);
    irq_in = 8'h01;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // irq_in[0] held high through release: no edge until it has been low.
    v = '{irq:8'h01, wr:1, din:8'hFF, ack:0, eoi:0, x_int:0, x_id:0, x_svc:0, x_pend:8'h00};
    run_vec(v);
    v = '{irq:8'h01, wr:0, din:8'h00, ack:0, eoi:0, x_int:0, x_id:0, x_svc:0, x_pend:8'h00};
    run_vec(v);
    run_vec(v);
    v = '{irq:8'h00, wr:0, din:8'h00, ack:0, eoi:0, x_int:0, x_id:0, x_svc:0, x_pend:8'h00};
    run_vec(v);
    v = '{irq:8'h01, wr:0, din:8'h00, ack:0, eoi:0, x_int:0, x_id:0, x_svc:0, x_pend:8'h01};
    run_vec(v);
    v = '{irq:8'h00, wr:0, din:8'h00, ack:0, eoi:0, x_int:1, x_id:0, x_svc:0, x_pend:8'h01};
    run_vec(v);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
